// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one pipelined fp_mul with in-order tagged result routing
module fp_mul_arbiter #(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int NUM_REQ          = 4,
    parameter int REQ_IDX_WIDTH    = 2,
    parameter int MUL_LATENCY      = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clk_en,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_dataa,
    input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_datab,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [FLOAT_DATA_WIDTH-1:0]         resp_data,
    output logic [FLOAT_DATA_WIDTH-1:0]         mul_dataa,
    output logic [FLOAT_DATA_WIDTH-1:0]         mul_datab,
    output logic                                mul_clk_en,
    output logic                                mul_aclr,
    input  logic [FLOAT_DATA_WIDTH-1:0]         mul_result,
    output logic                                busy
);
    localparam int STAGES = MUL_LATENCY + 1;

    logic [NUM_REQ-1:0]                      grant_q, grant_d;
    logic [NUM_REQ-1:0]                      resp_valid_q, resp_valid_d;
    logic [FLOAT_DATA_WIDTH-1:0]             resp_data_q, resp_data_d;
    logic [FLOAT_DATA_WIDTH-1:0]             mul_dataa_q, mul_dataa_d;
    logic [FLOAT_DATA_WIDTH-1:0]             mul_datab_q, mul_datab_d;
    logic [REQ_IDX_WIDTH-1:0]                ptr_q, ptr_d;
    logic [STAGES-1:0]                       tag_vld_q, tag_vld_d;
    logic [STAGES-1:0][REQ_IDX_WIDTH-1:0]    tag_idx_q, tag_idx_d;

    logic [NUM_REQ-1:0]                      elig, hi_elig, pick, pick_oh;
    logic                                    win_found, resp_fire;
    logic [REQ_IDX_WIDTH-1:0]                win_idx;
    logic [FLOAT_DATA_WIDTH-1:0]             op_a, op_b;

    // Round-robin pick: lowest eligible index at/above the pointer, else lowest overall (wrap)
    always_comb begin
        elig      = req & ~grant_q;
        hi_elig   = elig & ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1));
        pick      = (|hi_elig) ? hi_elig : elig;
        pick_oh   = pick & (~pick + NUM_REQ'(1));
        win_found = |pick_oh;
        win_idx   = '0;
        op_a      = '0;
        op_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx = pick_oh[i] ? REQ_IDX_WIDTH'(i) : win_idx;
            op_a    = pick_oh[i] ? req_dataa[i*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH] : op_a;
            op_b    = pick_oh[i] ? req_datab[i*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH] : op_b;
        end
    end

    // Next state: issue, tag shift and result routing advance only on enabled cycles
    always_comb begin
        resp_fire    = clk_en & tag_vld_q[STAGES-1];
        grant_d      = clk_en ? pick_oh : '0;
        ptr_d        = (clk_en && win_found) ?
                       ((win_idx == REQ_IDX_WIDTH'(NUM_REQ-1)) ? '0 : win_idx + 1'b1) : ptr_q;
        mul_dataa_d  = (clk_en && win_found) ? op_a : mul_dataa_q;
        mul_datab_d  = (clk_en && win_found) ? op_b : mul_datab_q;
        tag_vld_d    = clk_en ? {tag_vld_q[STAGES-2:0], win_found} : tag_vld_q;
        tag_idx_d    = clk_en ? {tag_idx_q[STAGES-2:0], win_idx} : tag_idx_q;
        resp_valid_d = resp_fire ? (NUM_REQ'(1) << tag_idx_q[STAGES-1]) : '0;
        resp_data_d  = resp_fire ? mul_result : resp_data_q;
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            mul_dataa_q  <= '0;
            mul_datab_q  <= '0;
            ptr_q        <= '0;
            tag_vld_q    <= '0;
            tag_idx_q    <= '0;
        end else begin
            grant_q      <= grant_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mul_dataa_q  <= mul_dataa_d;
            mul_datab_q  <= mul_datab_d;
            ptr_q        <= ptr_d;
            tag_vld_q    <= tag_vld_d;
            tag_idx_q    <= tag_idx_d;
        end
    end

    assign grant      = grant_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mul_dataa  = mul_dataa_q;
    assign mul_datab  = mul_datab_q;
    assign mul_clk_en = clk_en;
    assign mul_aclr   = ~rst;
    assign busy       = |tag_vld_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: randomized and directed bench with a stand-in fp_mul and a response scoreboard
module tb_fp_mul_arbiter;
    localparam int W = 32;
    localparam int N = 4;
    localparam int L = 3;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clk_en = 1'b1;
    logic [N-1:0]      req = '0;
    logic [W-1:0]      a [N];
    logic [W-1:0]      b [N];
    logic [N*W-1:0]    req_dataa, req_datab;
    logic [N-1:0]      grant, resp_valid;
    logic [W-1:0]      resp_data, mul_dataa, mul_datab, mul_result;
    logic              mul_clk_en, mul_aclr, busy;
    logic [W-1:0]      pipe [L];

    int                errors = 0;
    int                checks = 0;
    int                cnt = 0;
    int                ptr = 0;
    logic [N-1:0]      exp_grant = '0;
    resp_t             q[$];

    fp_mul_arbiter #(
        .FLOAT_DATA_WIDTH(W), .NUM_REQ(N), .REQ_IDX_WIDTH(2), .MUL_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .req(req),
        .req_dataa(req_dataa), .req_datab(req_datab),
        .grant(grant), .resp_valid(resp_valid), .resp_data(resp_data),
        .mul_dataa(mul_dataa), .mul_datab(mul_datab),
        .mul_clk_en(mul_clk_en), .mul_aclr(mul_aclr),
        .mul_result(mul_result), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_dataa = '0;
        req_datab = '0;
        for (int i = 0; i < N; i++) begin
            req_dataa[i*W +: W] = a[i];
            req_datab[i*W +: W] = b[i];
        end
    end

    // IEEE single multiply for normal operands with normal products, round-to-nearest-even
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] p;
        logic [24:0] m;
        logic [9:0]  e;
        logic        g, s;
        p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127;
        if (p[47]) begin
            m = {1'b0, p[47:24]}; g = p[23]; s = |p[22:0]; e = e + 10'd1;
        end else begin
            m = {1'b0, p[46:23]}; g = p[22]; s = |p[21:0];
        end
        if (g && (s || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1; e = e + 10'd1;
        end
        return {x[31] ^ y[31], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    // Stand-in fp_mul: L enabled cycles from operands to result, async clear
    always @(posedge clk or posedge mul_aclr) begin
        if (mul_aclr) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
        end else if (mul_clk_en) begin
            pipe[0] <= fmul(mul_dataa, mul_datab);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_result = pipe[L-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbiter: first requester at/after the pointer not granted on the previous edge
    task automatic model_edge();
        int w;
        logic [N-1:0] elig;
        if (!rst) return;
        if (!clk_en) begin
            exp_grant = '0;
            return;
        end
        cnt++;
        elig = req & ~exp_grant;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && elig[(ptr + k) % N]) w = (ptr + k) % N;
        if (w >= 0) begin
            exp_grant = N'(1) << w;
            ptr = (w + 1) % N;
            q.push_back('{w, fmul(a[w], b[w]), cnt + L + 1});
        end else begin
            exp_grant = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("mul_clk_en", 32'(mul_clk_en), 32'(clk_en));
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mul_dataa", mul_dataa, 0);
        chk("rst_mul_datab", mul_datab, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mul_aclr", 32'(mul_aclr), 1);
        q.delete();
        ptr = 0;
        exp_grant = '0;
        req = '0;
        tick();
        #2 rst = 1'b1;
    endtask

    // Response scoreboard: order, routing, data and exact timing of every result pulse
    always @(negedge clk) begin : mon
        resp_t e;
        if (rst) begin
            if (resp_valid != '0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_resp: resp_valid=%b with nothing in flight", resp_valid);
                end else begin
                    e = q.pop_front();
                    if (resp_valid != (N'(1) << e.idx) || resp_data != e.data || e.due != cnt) begin
                        errors++;
                        $display("FAIL resp: got valid=%b data=%h at cycle %0d expected valid=%b data=%h at cycle %0d",
                                 resp_valid, resp_data, cnt, N'(1) << e.idx, e.data, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cnt) begin
                checks++;
                errors++;
                $display("FAIL missing_resp: got none expected idx %0d data %h due cycle %0d", q[0].idx, q[0].data, q[0].due);
                e = q.pop_front();
            end
            checks++;
            if (busy != (q.size() != 0)) begin
                errors++;
                $display("FAIL busy: got %b expected %b", busy, q.size() != 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = 32'h3F800000;
            b[i] = 32'h3F800000;
        end
        do_reset();

        // single request: 2.0 * 3.0
        a[0] = 32'h40000000; b[0] = 32'h40400000; req = 4'b0001;
        tick();
        chk("t1_grant", 32'(grant), 1);
        chk("t1_busy", 32'(busy), 1);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_no_resp", 32'(resp_valid), 0);
        end
        tick();
        chk("t1_resp_valid", 32'(resp_valid), 1);
        chk("t1_resp_data", resp_data, 32'h40C00000);
        chk("t1_busy_low", 32'(busy), 0);

        // all four held from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) begin
            a[i] = rnd_fp(); b[i] = rnd_fp();
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_grant", 32'(grant), 32'(1) << (k % 4));
        end
        req = '0;
        repeat (6) tick();

        // back-to-back from one requester: masked every other cycle
        a[2] = 32'h3FC00000; b[2] = 32'h3FC00000; req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) req = '0;
            tick();
            chk("t3_grant", 32'(grant), (k < 6 && k % 2 == 0) ? 32'd4 : 32'd0);
            chk("t3_resp_valid", 32'(resp_valid), (k >= 4 && k <= 8 && k % 2 == 0) ? 32'd4 : 32'd0);
            if (k == 4 || k == 6 || k == 8) chk("t3_resp_data", resp_data, 32'h40100000);
        end

        // stall one cycle after a grant
        a[1] = rnd_fp(); b[1] = rnd_fp(); req = 4'b0010;
        tick();
        chk("t4_grant", 32'(grant), 2);
        req = '0;
        tick();
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_stall_grant", 32'(grant), 0);
            chk("t4_stall_resp", 32'(resp_valid), 0);
        end
        clk_en = 1'b1;
        tick();
        chk("t4_resp_early1", 32'(resp_valid), 0);
        tick();
        chk("t4_resp_early2", 32'(resp_valid), 0);
        tick();
        chk("t4_resp", 32'(resp_valid), 2);
        tick();
        chk("t4_resp_once", 32'(resp_valid), 0);

        // reset two cycles after a grant: the operation vanishes, pointer back to 0
        a[0] = rnd_fp(); b[0] = rnd_fp(); req = 4'b0001;
        tick();
        chk("t5_grant", 32'(grant), 1);
        req = '0;
        tick();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_no_resp", 32'(resp_valid), 0);
        end
        a[3] = rnd_fp(); b[3] = rnd_fp(); req = 4'b1001;
        tick();
        chk("t5_first_grant", 32'(grant), 1);
        req = '0;
        repeat (6) tick();

        // req[1] and req[3] together with the pointer at 2
        a[1] = rnd_fp(); b[1] = rnd_fp(); req = 4'b0010;
        tick();
        req = '0;
        tick();
        req = 4'b1010;
        tick();
        chk("t6_grant3", 32'(grant), 8);
        tick();
        chk("t6_grant1", 32'(grant), 2);
        req = '0;
        repeat (6) tick();

        // randomized traffic with stalls and one reset
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            clk_en = ($urandom_range(0, 99) < 85);
            tick();
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i]) begin
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    a[i] = rnd_fp();
                    b[i] = rnd_fp();
                end
            end
        end
        clk_en = 1'b1;
        req = '0;
        repeat (8) tick();
        chk("drain_empty", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one pipelined fp_mul instance between NUM_REQ requesters, for example the two squared-term multiplies and the CORDIC-result multiplies in the final adder.
- Arbitrates round-robin, issues at most one multiply per enabled cycle, and tracks in-flight operations with a tag pipeline.
- Routes each result back to the requester that issued it, in issue order.
- Sits between the final-adder stage controllers and the single shared multiplier.

Parameters:
- FLOAT_DATA_WIDTH, 32, operand/result width (IEEE-754 single).
- NUM_REQ, 4, number of requesters (2..8).
- REQ_IDX_WIDTH, 2, ceil(log2(NUM_REQ)).
- MUL_LATENCY, 3, fp_mul latency in enabled clock cycles (operands in cycle c, result valid in cycle c+MUL_LATENCY).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  global enable; low = stall.
- req  in  NUM_REQ  per-requester request level.
- req_dataa  in  NUM_REQ*FLOAT_DATA_WIDTH  operand A, requester i at bits [i*32 +: 32].
- req_datab  in  NUM_REQ*FLOAT_DATA_WIDTH  operand B, same packing.
- grant  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse.
- resp_data  out  FLOAT_DATA_WIDTH  product for the requester flagged in resp_valid.
- mul_dataa  out  FLOAT_DATA_WIDTH  to fp_mul dataa.
- mul_datab  out  FLOAT_DATA_WIDTH  to fp_mul datab.
- mul_clk_en  out  1  to fp_mul clk_en; equals clk_en.
- mul_aclr  out  1  to fp_mul aclr; equals ~rst.
- mul_result  in  FLOAT_DATA_WIDTH  from fp_mul result.
- busy  out  1  any operation in flight.

Behaviour:
- **Reset (rst=0, async):** grant=0, resp_valid=0, resp_data=0, mul_dataa=0, mul_datab=0, busy=0. All tag valids clear and the round-robin pointer goes to 0. In-flight operations are discarded and no response is ever produced for them.
- **Edge with clk_en=1:**
  - Eligible set = req & ~grant. The currently granted requester is masked, so a held req is not granted twice.
  - Winner = first eligible index at or after the pointer, wrapping modulo NUM_REQ.
  - If there is a winner w: grant<=onehot(w); mul_dataa/mul_datab<=req_dataa/req_datab of w; tag stage 0<={1,w}; pointer<=(w+1) mod NUM_REQ.
  - If there is no winner: grant<=0, operands hold their value, tag stage 0<={0,x}.
- **Requester handshake:**
  - Hold req and operands stable until the cycle grant[i]=1 inclusive.
  - Deassert req after that cycle, or keep it high to issue another operation; it becomes eligible again on the next edge.
  - Operands are sampled on the same edge that sets grant.
- **Tag pipeline:**
  - MUL_LATENCY+1 stages; shifts on every clk_en=1 edge.
  - When the last stage holds {1,k}, on that edge: resp_valid<=onehot(k), resp_data<=mul_result. Otherwise resp_valid<=0 and resp_data holds.
- **Latency:** grant visible in cycle c (operands on mul_* in cycle c); resp_valid in cycle c+MUL_LATENCY+1 (enabled cycles).
- **Throughput:** one issue per enabled cycle; responses return in issue order; unlimited outstanding per requester.
- **Edge with clk_en=0:** grant<=0, resp_valid<=0; pointer, tags, operands and resp_data hold. Each response pulses exactly once, after the stall ends.
- **Derived outputs:** busy = OR of all tag valids, combinational from registers.
- **Reset mid-operation:** everything clears immediately; the first legal grant is on the first enabled edge after rst returns high.
- **Arithmetic:** none in this block; product accuracy is fp_mul's.

Test Plan:
- **Single request:** req[0]=1 with A=0x40000000 (2.0), B=0x40400000 (3.0) -> grant[0] one cycle. Then resp_valid[0] exactly 4 cycles later with resp_data=0x40C00000. busy goes high with the grant and low after the response.
- **All four req held for 8 cycles, pointer=0:** grants are 0,1,2,3,0,1,2,3 on consecutive cycles; each resp_valid index matches the grant order, delayed by 4.
- **Back-to-back from one requester:** req[2] held, A=B=0x3FC00000 (1.5) -> grant[2] on alternate cycles only (masking). Each response is 0x40100000 (2.25).
- **Stall:** clk_en=0 for 5 cycles one cycle after a grant -> no grant/resp_valid during the stall. The response appears after 3 further enabled cycles, exactly once.
- **Reset mid-flight:** rst=0 for one cycle two cycles after a grant -> all outputs 0, no resp_valid ever for that operation. The next grant starts from index 0.
- **Simultaneous req[1] and req[3] with pointer=2:** grant[3] first, then grant[1].
